conv_window_mac: RTL and testbench
==================================

Name: conv_window_mac

Overview:
- Datapath slave of the convolution control FSM. Consumes pushpixel/multi_act strobes and produces the done/fin status that FSM samples.
- On each pushpixel it fetches one raster-order pixel from external image memory into two line buffers plus a 3x3 window.
- On each multi_act it runs a 9-tap sequential MAC against a signed kernel and emits one convolution result per valid window.

Parameters:
- IMG_W, 8, image width in pixels (>=3)
- IMG_H, 8, image height in pixels (>=3)
- PIX_W, 8, unsigned pixel width
- K_W, 8, signed coefficient width
- ACC_W, 20, signed accumulator/result width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  clears counters, buffers and fin; begins a new frame
- pushpixel  in  1  fetch/shift one pixel
- multi_act  in  1  request MAC on current window
- coef  in  9*K_W  kernel; tap k at bits [k*K_W +: K_W]
- pix_addr  out  $clog2(IMG_W*IMG_H)  address of the next pixel to fetch
- pix_in  in  PIX_W  memory data for pix_addr, combinational read
- done  out  1  one-cycle pulse: multi_act request finished
- fin  out  1  level: whole frame processed
- out_valid  out  1  one-cycle pulse: out_data valid
- out_data  out  ACC_W  signed convolution result
- out_row  out  $clog2(IMG_H)  output row (window centre)
- out_col  out  $clog2(IMG_W)  output column (window centre)

Behaviour:
- Reset, sampled at posedge when rst_n=0: pix_addr=0, row/col counters=0, line buffers and window=0, busy=0, done=0, fin=0, out_valid=0, out_data=0, out_row=0, out_col=0. Reset mid-MAC aborts the MAC with no done or out_valid.
- Priority: rst_n > start > pushpixel/multi_act. start clears everything reset clears except coef; no done is emitted for the request it kills.
- Accepted pushpixel: only when busy=0 and fin=0; otherwise ignored.
  - Sample pix_in at the current pix_addr.
  - Shift pix_in into the window bottom row and line buffers.
  - Record the pushed position (r,c); pix_addr+1; col wraps IMG_W-1 -> 0 with row+1.
  - pix_addr saturates at IMG_W*IMG_H-1 once the last pixel has been pushed.
- Window layout: tap k=3*i+j, with i=0 the oldest row and j=0 the oldest column. tap0=(r-2,c-2), tap8=(r,c).
- Window is valid iff r>=2 and c>=2 for the last pushed pixel. Row-wrap pixels never form a window.
- multi_act sampled in cycle t with busy=0:
  - Window valid: busy=1 from t+1. Accumulate one tap per cycle, t+1..t+9, acc += $signed({1'b0,pixel}) * $signed(coef[k]), k=0..8.
  - In cycle t+10: done=1, out_valid=1, out_data=acc, out_row=r-1, out_col=c-1, busy=0.
  - Window invalid (or no pixel pushed yet): done=1 in t+1, out_valid stays 0, no busy.
- multi_act while busy=1 is ignored. multi_act and pushpixel in the same idle cycle: the push happens first, and the MAC uses the updated window.
- Arithmetic:
  - Products are PIX_W+K_W+1 bits signed, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W with no saturation. Defaults cannot overflow (max |sum| = 9*255*128 < 2^19).
- fin:
  - Set in the same cycle as the done that answers the multi_act following the IMG_W*IMG_H-th push.
  - Held high until start or reset. While fin=1, pushpixel and multi_act are ignored.
- out_data, out_row and out_col hold their last value between out_valid pulses.

Test Plan:
- IMG_W=IMG_H=4, all coef=1, all pixels=10, alternate push/multi_act over 16 pixels -> exactly 4 out_valid with out_data=90 at (1,1),(1,2),(2,1),(2,2); fin high after the 16th done.
- Pixel value = address, coef tap4=1 and others 0 -> each out_data equals the pixel at (out_row,out_col).
- Coef tap0=-1, tap8=+1, pixels 0..15 on 4x4 -> every out_data=10 (i.e. (r,c)-(r-2,c-2) = 2*IMG_W+2); all pixels=255 with all coef=-128 -> out_data=-293760.
- Latency: multi_act at cycle t on a valid window -> done and out_valid exactly at t+10; on an invalid window -> done at t+1, no out_valid; pushpixel/multi_act during busy -> pix_addr unchanged, no extra done.
- rst_n low at MAC cycle 5 -> no done, all outputs 0 next cycle; start while fin=1 -> fin=0, pix_addr=0, and the frame reprocesses with identical results.

Source files
------------

// File: rtl/conv_window_mac.sv
// conv_window_mac: raster pixel fetch into two line buffers plus a 3x3 window,
// and a 9-cycle sequential MAC producing one convolution result per request.
module conv_window_mac #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int PIX_W = 8,
    parameter int K_W   = 8,
    parameter int ACC_W = 20
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              pushpixel,
    input  logic                              multi_act,
    input  logic [9*K_W-1:0]                  coef,
    output logic [$clog2(IMG_W*IMG_H)-1:0]    pix_addr,
    input  logic [PIX_W-1:0]                  pix_in,
    output logic                              done,
    output logic                              fin,
    output logic                              out_valid,
    output logic signed [ACC_W-1:0]           out_data,
    output logic [$clog2(IMG_H)-1:0]          out_row,
    output logic [$clog2(IMG_W)-1:0]          out_col
);

    localparam int NPIX   = IMG_W * IMG_H;
    localparam int AW     = $clog2(NPIX);
    localparam int RW     = $clog2(IMG_H);
    localparam int CW     = $clog2(IMG_W);
    localparam int PROD_W = PIX_W + K_W + 1;

    // index 0 of each line buffer is the most recently pushed pixel
    logic [IMG_W-1:0][PIX_W-1:0] lb1_q, lb1_d, lb2_q, lb2_d;
    // window tap k = 3*i + j, i=0 oldest row, j=0 oldest column
    logic [8:0][PIX_W-1:0]       win_q, win_d;

    logic [AW-1:0]           pix_addr_q, pix_addr_d;
    logic [RW-1:0]           row_q, row_d, last_r_q, last_r_d, out_row_q, out_row_d;
    logic [CW-1:0]           col_q, col_d, last_c_q, last_c_d, out_col_q, out_col_d;
    logic                    pushed_q, pushed_d, all_pushed_q, all_pushed_d;
    logic                    busy_q, busy_d, done_q, done_d, fin_q, fin_d;
    logic                    out_valid_q, out_valid_d;
    logic [3:0]              tap_q, tap_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, out_data_q, out_data_d;

    logic                    push_ok, mac_ok, win_valid;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;

    // next-state: pixel fetch/shift, window validity, MAC sequencing, status
    always_comb begin
        lb1_d        = lb1_q;
        lb2_d        = lb2_q;
        win_d        = win_q;
        pix_addr_d   = pix_addr_q;
        row_d        = row_q;
        col_d        = col_q;
        last_r_d     = last_r_q;
        last_c_d     = last_c_q;
        pushed_d     = pushed_q;
        all_pushed_d = all_pushed_q;
        busy_d       = busy_q;
        tap_d        = tap_q;
        acc_d        = acc_q;
        done_d       = 1'b0;
        out_valid_d  = 1'b0;
        fin_d        = fin_q;
        out_data_d   = out_data_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;

        // once the last pixel is in there is nothing left to fetch
        push_ok = pushpixel && !busy_q && !fin_q && !all_pushed_q;
        mac_ok  = multi_act && !busy_q && !fin_q;

        prod     = $signed({1'b0, win_q[tap_q]}) * $signed(coef[tap_q*K_W +: K_W]);
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

        if (push_ok) begin
            lb1_d = {lb1_q[IMG_W-2:0], pix_in};
            lb2_d = {lb2_q[IMG_W-2:0], lb1_q[IMG_W-1]};
            for (int i = 0; i < 3; i++) begin
                win_d[3*i]   = win_q[3*i+1];
                win_d[3*i+1] = win_q[3*i+2];
            end
            win_d[2] = lb2_q[IMG_W-1];   // (r-2, c)
            win_d[5] = lb1_q[IMG_W-1];   // (r-1, c)
            win_d[8] = pix_in;           // (r, c)
            last_r_d = row_q;
            last_c_d = col_q;
            pushed_d = 1'b1;
            if (pix_addr_q == AW'(NPIX-1)) all_pushed_d = 1'b1;
            else                           pix_addr_d   = pix_addr_q + 1'b1;
            if (col_q == CW'(IMG_W-1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // uses post-push position so a same-cycle push feeds the MAC
        win_valid = pushed_d && (last_r_d >= RW'(2)) && (last_c_d >= CW'(2));

        if (busy_q) begin
            acc_d = acc_q + prod_ext;
            tap_d = tap_q + 4'd1;
            if (tap_q == 4'd8) begin
                busy_d      = 1'b0;
                done_d      = 1'b1;
                out_valid_d = 1'b1;
                out_data_d  = acc_d;
                out_row_d   = last_r_q - 1'b1;
                out_col_d   = last_c_q - 1'b1;
                fin_d       = all_pushed_q;
            end
        end else if (mac_ok) begin
            if (win_valid) begin
                busy_d = 1'b1;
                tap_d  = '0;
                acc_d  = '0;
            end else begin
                done_d = 1'b1;
                fin_d  = all_pushed_d;
            end
        end
    end

    // state registers; start clears exactly what reset clears
    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            lb1_q        <= '0;
            lb2_q        <= '0;
            win_q        <= '0;
            pix_addr_q   <= '0;
            row_q        <= '0;
            col_q        <= '0;
            last_r_q     <= '0;
            last_c_q     <= '0;
            pushed_q     <= 1'b0;
            all_pushed_q <= 1'b0;
            busy_q       <= 1'b0;
            tap_q        <= '0;
            acc_q        <= '0;
            done_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            fin_q        <= 1'b0;
            out_data_q   <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            lb1_q        <= lb1_d;
            lb2_q        <= lb2_d;
            win_q        <= win_d;
            pix_addr_q   <= pix_addr_d;
            row_q        <= row_d;
            col_q        <= col_d;
            last_r_q     <= last_r_d;
            last_c_q     <= last_c_d;
            pushed_q     <= pushed_d;
            all_pushed_q <= all_pushed_d;
            busy_q       <= busy_d;
            tap_q        <= tap_d;
            acc_q        <= acc_d;
            done_q       <= done_d;
            out_valid_q  <= out_valid_d;
            fin_q        <= fin_d;
            out_data_q   <= out_data_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
        end
    end

    assign pix_addr  = pix_addr_q;
    assign done      = done_q;
    assign fin       = fin_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// tb_conv_window_mac: scoreboard bench on a 4x4 frame; expected results are
// computed from the bench's own image/kernel copy when multi_act is driven.
module tb_conv_window_mac;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;
    localparam int KW = 8;
    localparam int AW = 20;

    logic             clk = 1'b0;
    logic             rst_n, start, pushpixel, multi_act;
    logic [9*KW-1:0]  coef;
    logic [3:0]       pix_addr;
    logic [PW-1:0]    pix_in;
    logic             done, fin, out_valid;
    logic signed [AW-1:0] out_data;
    logic [1:0]       out_row, out_col;

    logic [PW-1:0]    mem [16];
    int               kc  [9];

    typedef struct { int data; int row; int col; } exp_t;
    exp_t sb[$];

    int n_tests = 0, n_fail = 0;
    int done_cnt = 0, ov_cnt = 0, npushed = 0;

    always #5 clk = ~clk;

    conv_window_mac #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .K_W(KW), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pushpixel(pushpixel),
        .multi_act(multi_act), .coef(coef), .pix_addr(pix_addr), .pix_in(pix_in),
        .done(done), .fin(fin), .out_valid(out_valid), .out_data(out_data),
        .out_row(out_row), .out_col(out_col)
    );

    assign pix_in = mem[pix_addr];

    always_comb begin
        coef = '0;
        for (int k = 0; k < 9; k++) coef[k*KW +: KW] = kc[k][KW-1:0];
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int r, input int c);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'(mem[(r-2+i)*W + (c-2+j)]) * kc[3*i+j];
        return s;
    endfunction

    // output monitor: every out_valid pops one expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (done) done_cnt++;
        if (out_valid) begin
            ov_cnt++;
            if (sb.size() == 0) check("ov_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                check("out_data", $signed(out_data), e.data);
                check("out_row", out_row, e.row);
                check("out_col", out_col, e.col);
                check("ov_with_done", done, 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_push();
        pushpixel = 1'b1;
        npushed++;
        @(negedge clk);
        pushpixel = 1'b0;
    endtask

    task automatic do_mac(input bit with_push);
        int r, c, lat, exp_lat;
        bit v;
        exp_t e;
        if (with_push) begin
            pushpixel = 1'b1;
            npushed++;
        end
        multi_act = 1'b1;
        r = (npushed - 1) / W;
        c = (npushed - 1) % W;
        v = (npushed > 0) && (r >= 2) && (c >= 2);
        if (v) begin
            e.data = model(r, c); e.row = r - 1; e.col = c - 1;
            sb.push_back(e);
        end
        exp_lat = v ? 10 : 1;
        @(negedge clk);
        pushpixel = 1'b0;
        multi_act = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("mac_latency", done ? lat : -1, exp_lat);
        check("fin_after_done", fin, (npushed == W*H) ? 1 : 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        npushed = 0;
        check("start_fin", fin, 0);
        check("start_addr", pix_addr, 0);
    endtask

    task automatic run_frame(input bit comb);
        int ov0;
        ov0 = ov_cnt;
        for (int n = 0; n < W*H; n++) begin
            if (comb) do_mac(1'b1);
            else begin
                do_push();
                do_mac(1'b0);
            end
        end
        @(negedge clk);
        check("frame_ov_count", ov_cnt - ov0, 4);
        check("frame_fin", fin, 1);
    endtask

    initial begin : drv
        int a0, d0, lat;
        rst_n = 1'b0; start = 1'b0; pushpixel = 1'b0; multi_act = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'd10;
        for (int k = 0; k < 9; k++) kc[k] = 1;
        repeat (2) @(negedge clk);
        check("rst_addr", pix_addr, 0);
        check("rst_done", done, 0);
        check("rst_fin", fin, 0);
        check("rst_ov", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_rowcol", {out_row, out_col}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // all 10s, all-ones kernel: four results of 90
        run_frame(1'b0);

        // pixel = address, centre tap only; push and multi_act together
        do_start();
        for (int i = 0; i < 16; i++) mem[i] = PW'(i);
        for (int k = 0; k < 9; k++) kc[k] = (k == 4) ? 1 : 0;
        run_frame(1'b1);

        // corner difference kernel
        do_start();
        for (int k = 0; k < 9; k++) kc[k] = 0;
        kc[0] = -1; kc[8] = 1;
        run_frame(1'b0);

        // extreme magnitudes
        do_start();
        for (int i = 0; i < 16; i++) mem[i] = 8'd255;
        for (int k = 0; k < 9; k++) kc[k] = -128;
        run_frame(1'b0);

        // while fin is high, requests are ignored
        d0 = done_cnt;
        pushpixel = 1'b1; multi_act = 1'b1;
        @(negedge clk);
        pushpixel = 1'b0; multi_act = 1'b0;
        repeat (3) @(negedge clk);
        check("fin_ignore_done", done_cnt - d0, 0);
        check("fin_ignore_addr", pix_addr, 15);
        check("fin_hold", fin, 1);

        // restart reprocesses with identical results
        do_start();
        run_frame(1'b0);

        // requests during busy are ignored
        do_start();
        repeat (11) do_push();
        d0 = done_cnt;
        begin
            exp_t e;
            e.data = model(2, 2); e.row = 1; e.col = 1;
            sb.push_back(e);
        end
        multi_act = 1'b1;
        @(negedge clk);
        multi_act = 1'b0;
        repeat (2) @(negedge clk);
        a0 = pix_addr;
        pushpixel = 1'b1; multi_act = 1'b1;
        @(negedge clk);
        pushpixel = 1'b0; multi_act = 1'b0;
        check("busy_addr_hold", pix_addr, a0);
        lat = 4;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("busy_latency", done ? lat : -1, 10);
        repeat (5) @(negedge clk);
        check("busy_done_count", done_cnt - d0, 1);

        // reset in MAC cycle 5 aborts it silently
        do_start();
        repeat (11) do_push();
        d0 = done_cnt;
        multi_act = 1'b1;
        @(negedge clk);
        multi_act = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_done", done, 0);
        check("abort_ov", out_valid, 0);
        check("abort_data", out_data, 0);
        check("abort_rowcol", {out_row, out_col}, 0);
        check("abort_addr", pix_addr, 0);
        check("abort_fin", fin, 0);
        rst_n = 1'b1;
        npushed = 0;
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
